// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Pops bytes from the PS/2 receiver FIFO one at a time and interprets
//   scan-code set 2 make / break / E0-extended sequences. Tracks the held
//   key, converts it to lowercase ASCII, counts distinct presses and keeps
//   a sticky copy of the receiver overflow flag.
//
// Ports
//   clk          system clock, rising edge
//   clrn         asynchronous active-low reset
//   data         oldest receiver FIFO byte, valid while ready=1
//   ready        receiver FIFO non-empty
//   overflow     receiver FIFO overflow indicator
//   nextdata_n   registered active-low pop strobe (one cycle per byte)
//   key_code     scan code of the last make event
//   key_ext      last make event was E0-prefixed
//   key_down     key_code is currently held
//   ascii        ASCII of key_code, 0x00 when unmapped or extended
//   press_count  count of new make events, wraps silently
//   make_pulse   one-cycle strobe per new make event
//   ovf_seen     sticky overflow flag, cleared only by reset
//
// State    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for ready; captures data and requests a pop
// S_POP    | nextdata_n low; byte_r decoded, outputs update at end
// S_WAIT   | receiver advances its read pointer; inputs ignored

module ps2_scancode_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic [7:0]       ascii,
  output logic [CNT_W-1:0] press_count,
  output logic             make_pulse,
  output logic             ovf_seen
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [7:0]       byte_r, byte_nxt;
  logic             ext_pend, ext_nxt;
  logic             brk_pend, brk_nxt;
  logic [7:0]       code_nxt;
  logic             kext_nxt;
  logic             down_nxt;
  logic [7:0]       ascii_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pulse_nxt;
  logic             ndn_nxt;
  logic             same_key;

  function automatic logic [7:0] ps2_to_ascii(input logic [7:0] sc);
    logic [7:0] ch;
    case (sc)
      8'h1C: ch = 8'h61; // a
      8'h32: ch = 8'h62;
      8'h21: ch = 8'h63;
      8'h23: ch = 8'h64;
      8'h24: ch = 8'h65;
      8'h2B: ch = 8'h66;
      8'h34: ch = 8'h67;
      8'h33: ch = 8'h68;
      8'h43: ch = 8'h69;
      8'h3B: ch = 8'h6A;
      8'h42: ch = 8'h6B;
      8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D;
      8'h31: ch = 8'h6E;
      8'h44: ch = 8'h6F;
      8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71;
      8'h2D: ch = 8'h72;
      8'h1B: ch = 8'h73;
      8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75;
      8'h2A: ch = 8'h76;
      8'h1D: ch = 8'h77;
      8'h22: ch = 8'h78;
      8'h35: ch = 8'h79;
      8'h1A: ch = 8'h7A; // z
      8'h45: ch = 8'h30; // 0
      8'h16: ch = 8'h31;
      8'h1E: ch = 8'h32;
      8'h26: ch = 8'h33;
      8'h25: ch = 8'h34;
      8'h2E: ch = 8'h35;
      8'h36: ch = 8'h36;
      8'h3D: ch = 8'h37;
      8'h3E: ch = 8'h38;
      8'h46: ch = 8'h39; // 9
      8'h29: ch = 8'h20; // space
      8'h5A: ch = 8'h0D; // enter
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ready) state_nxt = S_POP;
      S_POP:   state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Same physical key as the one held: used for both typematic repeats
  // and matching breaks.
  assign same_key = key_down && (byte_r == key_code) && (ext_pend == key_ext);

  // Output / datapath next-value logic
  always_comb begin
    byte_nxt  = byte_r;
    ext_nxt   = ext_pend;
    brk_nxt   = brk_pend;
    code_nxt  = key_code;
    kext_nxt  = key_ext;
    down_nxt  = key_down;
    ascii_nxt = ascii;
    cnt_nxt   = press_count;
    pulse_nxt = 1'b0;
    ndn_nxt   = 1'b1;
    case (state)
      S_IDLE: begin
        if (ready) begin
          byte_nxt = data;
          ndn_nxt  = 1'b0;
        end
      end
      S_POP: begin
        if (byte_r == 8'hE0) begin
          ext_nxt = 1'b1;
        end else if (byte_r == 8'hF0) begin
          brk_nxt = 1'b1;
        end else if (byte_r == 8'h00 || byte_r == 8'hFF) begin
          // receiver error codes abandon any partial sequence
          ext_nxt = 1'b0;
          brk_nxt = 1'b0;
        end else begin
          ext_nxt = 1'b0;
          brk_nxt = 1'b0;
          if (brk_pend) begin
            if (same_key) down_nxt = 1'b0;
          end else if (!same_key) begin
            code_nxt  = byte_r;
            kext_nxt  = ext_pend;
            ascii_nxt = ext_pend ? 8'h00 : ps2_to_ascii(byte_r);
            down_nxt  = 1'b1;
            cnt_nxt   = press_count + CNT_W'(1);
            pulse_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      nextdata_n  <= 1'b1;
      byte_r      <= 8'h00;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_down    <= 1'b0;
      ascii       <= 8'h00;
      press_count <= '0;
      make_pulse  <= 1'b0;
      ovf_seen    <= 1'b0;
    end else begin
      nextdata_n  <= ndn_nxt;
      byte_r      <= byte_nxt;
      ext_pend    <= ext_nxt;
      brk_pend    <= brk_nxt;
      key_code    <= code_nxt;
      key_ext     <= kext_nxt;
      key_down    <= down_nxt;
      ascii       <= ascii_nxt;
      press_count <= cnt_nxt;
      make_pulse  <= pulse_nxt;
      ovf_seen    <= ovf_seen | overflow;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with a small receiver FIFO model.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;
  logic       overflow = 1'b0;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_down;
  logic [7:0] ascii;
  logic [7:0] press_count;
  logic       make_pulse;
  logic       ovf_seen;

  int checks = 0;
  int failures = 0;

  logic [7:0] fifo[$];

  int cyc = 0;
  int lows = 0;
  int pulses = 0;
  int width_bad = 0;
  int gap_bad = 0;
  int last_low = -100;
  bit prev_low = 1'b0;

  int lows0, pulses0;

  ps2_scancode_decoder #(.CNT_W(8)) dut (
    .clk(clk),
    .clrn(clrn),
    .data(data),
    .ready(ready),
    .overflow(overflow),
    .nextdata_n(nextdata_n),
    .key_code(key_code),
    .key_ext(key_ext),
    .key_down(key_down),
    .ascii(ascii),
    .press_count(press_count),
    .make_pulse(make_pulse),
    .ovf_seen(ovf_seen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (clrn && !nextdata_n && fifo.size() > 0) void'(fifo.pop_front());
  end

  always @(negedge clk) begin
    ready = (fifo.size() != 0);
    data  = ready ? fifo[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (clrn) begin
      if (!nextdata_n) begin
        lows++;
        if (prev_low) width_bad++;
        if (cyc - last_low < 3) gap_bad++;
        last_low = cyc;
      end
      prev_low = !nextdata_n;
      if (make_pulse) pulses++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic drain();
    int n = 0;
    while (fifo.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", fifo.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_ndn", nextdata_n, 1);
    check("rst_code", key_code, 0);
    check("rst_down", key_down, 0);
    check("rst_cnt", press_count, 0);
    check("rst_ovf", ovf_seen, 0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // reset asserted mid-POP aborts the pop
    send(8'h1C);
    n = 0;
    while (nextdata_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pop_seen", nextdata_n, 0);
    #1 clrn = 1'b0;
    #1 check("abort_ndn_async", nextdata_n, 1);
    check("abort_no_decode", key_code, 0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    lows0 = lows;
    pulses0 = pulses;
    @(negedge clk);
    check("pop_after_release", nextdata_n, 0);

    // make then break
    drain();
    check("mk_code", key_code, 8'h1C);
    check("mk_ascii", ascii, 8'h61);
    check("mk_down", key_down, 1);
    check("mk_cnt", press_count, 1);
    check("mk_pulses", pulses - pulses0, 1);
    send(8'hF0); send(8'h1C);
    drain();
    check("brk_down", key_down, 0);
    check("brk_code", key_code, 8'h1C);
    check("brk_lows", lows - lows0, 3);
    check("ndn_width", width_bad, 0);
    check("ndn_gap", gap_bad, 0);

    // typematic
    pulses0 = pulses;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    check("typ_cnt", press_count, 2);
    check("typ_pulses", pulses - pulses0, 1);
    check("typ_down", key_down, 0);

    // extended
    send(8'hE0); send(8'h75);
    drain();
    check("ext_code", key_code, 8'h75);
    check("ext_flag", key_ext, 1);
    check("ext_ascii", ascii, 8'h00);
    check("ext_down", key_down, 1);
    check("ext_cnt", press_count, 3);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain();
    check("ext_up", key_down, 0);
    send(8'h75);
    drain();
    check("plain_cnt", press_count, 4);
    check("plain_ext", key_ext, 0);
    check("plain_down", key_down, 1);
    send(8'hF0); send(8'h75);
    drain();

    // mismatched break and error codes
    send(8'h16);
    drain();
    check("k1_ascii", ascii, 8'h31);
    check("k1_cnt", press_count, 5);
    send(8'hF0); send(8'h1E);
    drain();
    check("mis_down", key_down, 1);
    check("mis_code", key_code, 8'h16);
    send(8'h00); send(8'h16);
    drain();
    check("err_rep_cnt", press_count, 5);
    send(8'hE0); send(8'h00); send(8'h16);
    drain();
    check("err_ext_cnt", press_count, 5);
    check("err_ext_flag", key_ext, 0);
    send(8'hF0); send(8'hE0); send(8'h16);
    drain();
    check("f0e0_mismatch", key_down, 1);
    send(8'hFF); send(8'hF0); send(8'h16);
    drain();
    check("ff_then_brk", key_down, 0);

    // wrap: 256 distinct alternating makes return the count to its start
    pulses0 = pulses;
    for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
    drain();
    check("wrap_cnt", press_count, 5);
    check("wrap_pulses", pulses - pulses0, 256);
    check("wrap_code", key_code, 8'h32);
    check("wrap_ascii", ascii, 8'h62);
    check("wrap_gap", gap_bad, 0);

    // overflow sticky
    check("ovf_pre", ovf_seen, 0);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    repeat (5) @(negedge clk);
    check("ovf_held", ovf_seen, 1);
    clrn = 1'b0;
    #1 check("ovf_clr", ovf_seen, 0);
    check("clr_cnt", press_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
